// File: rtl/tb_irq_pkg.sv
// Shared constants and types for the pseudo-random interrupt stimulus generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tb_irq_pkg;

  // Galois LFSR, polynomial x^32 + x^22 + x^2 + x + 1 in right-shift form
  localparam int              LFSR_W    = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  // Interrupt counter width and its saturation value
  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Gap counter width: MIN_GAP + 8-bit random part
  localparam int GAP_W = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } irq_state_e;

  // One right-shift Galois step: shift out bit 0, fold taps in when it was set
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/tb_lfsr32.sv
// Free-running 32-bit Galois LFSR used as the randomness source.
// Latency: state advances one step every clock after reset; output is the register.
// Backpressure: none, always steps.
//
// Ports:
//   sys_clk    clock
//   sys_rst_n  async active-low reset, loads SEED
//   lfsr_q     current LFSR state
module tb_lfsr32
  import tb_irq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2468
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic [LFSR_W-1:0] lfsr_q
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

endmodule

// File: rtl/tb_irq_generator.sv
// Seeded pseudo-random level-interrupt generator for SoC simulation benches.
// Latency: a fire attempt registers its set one edge after the gap counter hits 0.
// Backpressure: a line stays high until acked; pending or masked lines are never re-fired.
//
// Ports:
//   sys_clk     clock
//   sys_rst_n   async active-low reset
//   en_i        generation enable
//   irq_mask_i  lines allowed to fire
//   irq_ack_i   per-line clear strobe
//   irq_o       level interrupt outputs (registered)
//   irq_cnt_o   total interrupts raised, saturating (registered)
module tb_irq_generator
  import tb_irq_pkg::*;
#(
  parameter int                NUM_IRQ  = 16,
  parameter logic [LFSR_W-1:0] SEED     = 32'hACE1_2468,
  parameter int                MIN_GAP  = 16,
  parameter logic [7:0]        GAP_MASK = 8'hFF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               en_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic [NUM_IRQ-1:0] irq_ack_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic [CNT_W-1:0]   irq_cnt_o
);

  localparam int IDX_W = $clog2(NUM_IRQ);

  logic [LFSR_W-1:0]  lfsr_q;
  logic               lfsr_unused;

  irq_state_e         state_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [GAP_W-1:0]   gap_val;

  logic               fire_attempt;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] low_vec;
  logic [NUM_IRQ-1:0] set_vec;

  logic [NUM_IRQ-1:0] irq_q;
  logic [CNT_W-1:0]   irq_cnt_q;

  tb_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .lfsr_q    (lfsr_q)
  );

  // Only the low byte (gap) and the index field are consumed
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:8+IDX_W];

  assign gap_val = GAP_W'(MIN_GAP) + {1'b0, lfsr_q[7:0] & GAP_MASK};

  // FSM and gap counter. Leaving WAIT keeps the counter value; IDLE always
  // reloads a fresh gap on re-enable, so a stale count never leaks through.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            gap_cnt_q <= gap_val;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!en_i) begin
            state_q <= ST_IDLE;
          end else if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end else begin
            gap_cnt_q <= gap_val;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Disable takes priority over an attempt due on the same edge
  assign fire_attempt = (state_q == ST_WAIT) && en_i && (gap_cnt_q == '0);

  assign eligible = irq_mask_i & ~irq_q;
  assign sel_idx  = lfsr_q[8 +: IDX_W];

  // Lowest-indexed eligible line, used when the random pick is not eligible
  always_comb begin
    logic found;
    low_vec = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && !found) begin
        low_vec[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    set_vec = '0;
    if (fire_attempt) begin
      if (eligible[sel_idx]) begin
        set_vec[sel_idx] = 1'b1;
      end else begin
        set_vec = low_vec;
      end
    end
  end

  // A set only ever hits a line that is currently low, so OR-ing it after the
  // ack mask lets it win over a same-cycle ack on that line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      irq_q     <= '0;
      irq_cnt_q <= '0;
    end else begin
      irq_q <= (irq_q & ~irq_ack_i) | set_vec;
      if ((set_vec != '0) && (irq_cnt_q != CNT_MAX)) begin
        irq_cnt_q <= irq_cnt_q + CNT_W'(1);
      end
    end
  end

  assign irq_o     = irq_q;
  assign irq_cnt_o = irq_cnt_q;

endmodule

// File: tb/tb_tb_irq_generator.sv
// Self-checking bench for tb_irq_generator: per-cycle vector table on a
// deterministic-gap instance, plus saturation/randomness on a fast instance.
module tb_tb_irq_generator;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        sys_clk = 1'b0;
  logic        rst1_n, rst2_n;
  logic        en1, en2;
  logic [15:0] mask1, mask2, ack1, ack2;
  logic [15:0] irq1, irq2, cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  // Deterministic gap of 4: attempts every 5 cycles
  tb_irq_generator #(
    .NUM_IRQ (16), .SEED (SEED), .MIN_GAP (4), .GAP_MASK (8'h00)
  ) dut1 (
    .sys_clk (sys_clk), .sys_rst_n (rst1_n), .en_i (en1),
    .irq_mask_i (mask1), .irq_ack_i (ack1), .irq_o (irq1), .irq_cnt_o (cnt1)
  );

  // Fastest rate: an attempt every 2 cycles
  tb_irq_generator #(
    .NUM_IRQ (16), .SEED (SEED), .MIN_GAP (1), .GAP_MASK (8'h00)
  ) dut2 (
    .sys_clk (sys_clk), .sys_rst_n (rst2_n), .en_i (en2),
    .irq_mask_i (mask2), .irq_ack_i (ack2), .irq_o (irq2), .irq_cnt_o (cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          n;
    logic        en;
    logic [15:0] mask;
    logic [15:0] ack;
    logic [15:0] exp_irq;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int          sets;
    int          cyc;
    int          s2;
    logic [15:0] prev;
    logic [15:0] seen;
    logic [15:0] rising;

    // Edge numbers in comments count posedges after reset release.
    vecs[0]  = '{5,    1'b1, 16'h0001, 16'h0000, 16'h0000, 16'd0}; // 1-5 counting down
    vecs[1]  = '{1,    1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd1}; // 6 first set (k+G+1)
    vecs[2]  = '{16,   1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd1}; // 7-22 pending, attempts skip
    vecs[3]  = '{1,    1'b1, 16'h0001, 16'h0001, 16'h0000, 16'd1}; // 23 ack clears
    vecs[4]  = '{1,    1'b1, 16'h0001, 16'h0002, 16'h0000, 16'd1}; // 24 ack on idle line
    vecs[5]  = '{1,    1'b1, 16'h0001, 16'h0000, 16'h0000, 16'd1}; // 25
    vecs[6]  = '{1,    1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd2}; // 26 re-fire
    vecs[7]  = '{4,    1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd2}; // 27-30
    vecs[8]  = '{1,    1'b1, 16'h0001, 16'h0001, 16'h0000, 16'd2}; // 31 ack on attempt edge, line pending
    vecs[9]  = '{4,    1'b1, 16'h0001, 16'h0000, 16'h0000, 16'd2}; // 32-35
    vecs[10] = '{1,    1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd3}; // 36 set
    vecs[11] = '{2,    1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd3}; // 37-38 counter 3,2
    vecs[12] = '{11,   1'b0, 16'h0001, 16'h0000, 16'h0001, 16'd3}; // 39-49 disabled, pending holds
    vecs[13] = '{1,    1'b0, 16'h0001, 16'h0001, 16'h0000, 16'd3}; // 50 ack while disabled
    vecs[14] = '{8,    1'b0, 16'h0001, 16'h0000, 16'h0000, 16'd3}; // 51-58
    vecs[15] = '{5,    1'b1, 16'h0001, 16'h0000, 16'h0000, 16'd3}; // 59-63 re-enabled
    vecs[16] = '{1,    1'b1, 16'h0001, 16'h0000, 16'h0001, 16'd4}; // 64 = 59 + MIN_GAP + 1
    vecs[17] = '{1,    1'b1, 16'h0001, 16'h0001, 16'h0000, 16'd4}; // 65
    vecs[18] = '{3,    1'b1, 16'h0001, 16'h0000, 16'h0000, 16'd4}; // 66-68
    vecs[19] = '{1,    1'b0, 16'h0001, 16'h0000, 16'h0000, 16'd4}; // 69 drop en at counter=0
    vecs[20] = '{11,   1'b0, 16'h0001, 16'h0000, 16'h0000, 16'd4}; // 70-80
    vecs[21] = '{1000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'd4}; // all lines masked

    // Reset held with enable high
    rst1_n = 1'b0; rst2_n = 1'b0;
    en1 = 1'b1; mask1 = 16'h0001; ack1 = '0;
    en2 = 1'b0; mask2 = '0;       ack2 = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_irq1", 32'(irq1), 32'h0);
    check("rst_cnt1", 32'(cnt1), 32'h0);
    check("rst_irq2", 32'(irq2), 32'h0);
    check("rst_cnt2", 32'(cnt2), 32'h0);
    rst1_n = 1'b1; rst2_n = 1'b1;
    #1;
    check("lfsr_seed", dut1.u_lfsr.lfsr_q, SEED);

    // Per-cycle vector table
    for (int v = 0; v < 22; v++) begin
      for (int c = 0; c < vecs[v].n; c++) begin
        en1   = vecs[v].en;
        mask1 = vecs[v].mask;
        ack1  = vecs[v].ack;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check($sformatf("vec%0d.%0d_irq", v, c), 32'(irq1), 32'(vecs[v].exp_irq));
        check($sformatf("vec%0d.%0d_cnt", v, c), 32'(cnt1), 32'(vecs[v].exp_cnt));
      end
    end
    ack1 = '0;

    // Mid-operation asynchronous reset
    mask1 = 16'h0001; en1 = 1'b1;
    cyc = 0;
    while (irq1[0] !== 1'b1 && cyc < 20) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      cyc++;
    end
    check("pre_reset_irq", 32'(irq1), 32'h1);
    check("pre_reset_cnt", 32'(cnt1), 32'd5);
    #2 rst1_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq1), 32'h0);
    check("async_rst_cnt", 32'(cnt1), 32'h0);
    check("async_rst_lfsr", dut1.u_lfsr.lfsr_q, SEED);
    en1 = 1'b0;
    @(negedge sys_clk);
    rst1_n = 1'b1;

    // Randomness: all lines enabled, every set acked right away
    en2 = 1'b1; mask2 = 16'hFFFF;
    prev = '0; seen = '0; sets = 0; cyc = 0;
    while (sets < 1024 && cyc < 4000) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      cyc++;
      rising = irq2 & ~prev;
      for (int i = 0; i < 16; i++) if (rising[i]) sets++;
      seen |= rising;
      prev = irq2;
      ack2 = irq2;
    end
    // en sampled at edge 1, sets at edges 3,5,...: set n lands at edge 2n+1
    check("sets_cycles", 32'(cyc), 32'd2049);
    check("sets_1024_cnt", 32'(cnt2), 32'd1024);
    check("all_lines_seen", 32'(seen), 32'h0000_FFFF);

    // Saturation: jump the counter close to the top, then keep firing
    force dut2.irq_cnt_q = 16'hFFF0;
    #1;
    release dut2.irq_cnt_q;
    s2 = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      rising = irq2 & ~prev;
      for (int i = 0; i < 16; i++) if (rising[i]) s2++;
      prev = irq2;
      ack2 = irq2;
      if (s2 == 14 && rising != '0) check("cnt_fffe", 32'(cnt2), 32'h0000_FFFE);
      if (s2 >= 15) check($sformatf("sat_hold%0d", c), 32'(cnt2), 32'h0000_FFFF);
    end
    check("sat_sets_seen", 32'(s2), 32'd30);
    check("sat_final", 32'(cnt2), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
